// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host sequencer: state encoding and job geometry.
// The state constants are plain logic localparams so legacy code can compare against them.
package tpu_pkg;

    localparam int NUM_OPERANDS = 8;
    localparam int NUM_RESULTS  = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_LOAD      = 3'd0;
    localparam state_t ST_WAIT_DONE = 3'd1;
    localparam state_t ST_GAP       = 3'd2;
    localparam state_t ST_READ      = 3'd3;
    localparam state_t ST_SEND      = 3'd4;

endpackage

// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer for a 2x2 TPU: streams operands into the load port,
// waits for done, reads back four results and returns them to the host.
module tpu_host_sequencer
    import tpu_pkg::*;
#(
    parameter int DONE_WAIT = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_last,
    output logic       busy,
    output logic       timeout,
    output logic       load_en,
    output logic       load_sel_ab,
    output logic [1:0] load_index,
    output logic [7:0] in_data,
    output logic       output_en,
    output logic [1:0] output_sel,
    input  logic [7:0] out_data,
    input  logic       done
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W  = (DONE_WAIT > 1) ? $clog2(DONE_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(DONE_WAIT - 1);
    localparam logic [2:0]        BYTE_LAST = 3'(NUM_OPERANDS - 1);
    localparam logic [1:0]        RES_LAST  = 2'(NUM_RESULTS - 1);
    // With no gap requested, done leads straight into the read burst.
    localparam state_t AFTER_DONE = (DONE_WAIT > 0) ? ST_GAP : ST_READ;

    state_t            state;
    logic [2:0]        byte_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        rd_idx;
    logic [1:0]        send_idx;
    logic [7:0]        res_buf [NUM_RESULTS];
    logic              xfer;
    logic              accept;

    assign cmd_ready  = (state == ST_LOAD);
    assign busy       = (state != ST_LOAD);
    assign xfer       = cmd_valid && cmd_ready;
    assign output_en  = (state == ST_READ);
    assign output_sel = output_en ? rd_idx : 2'd0;
    assign res_valid  = (state == ST_SEND);
    assign res_data   = res_valid ? res_buf[send_idx] : 8'd0;
    assign res_last   = res_valid && (send_idx == RES_LAST);
    assign accept     = res_valid && res_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_LOAD;
            byte_cnt    <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            rd_idx      <= '0;
            send_idx    <= '0;
            load_en     <= 1'b0;
            load_sel_ab <= 1'b0;
            load_index  <= '0;
            in_data     <= '0;
            timeout     <= 1'b0;
            // NOTE: the result buffer is reset explicitly; it is only four bytes
            // and stale results must never leak into a job after reset.
            for (int i = 0; i < NUM_RESULTS; i++) begin
                res_buf[i] <= '0;
            end
        end else begin
            load_en <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (xfer) begin
                        load_en     <= 1'b1;
                        load_sel_ab <= byte_cnt[2];
                        load_index  <= byte_cnt[1:0];
                        in_data     <= cmd_data;
                        byte_cnt    <= byte_cnt + 3'd1;
                        if (byte_cnt == BYTE_LAST) begin
                            state    <= ST_WAIT_DONE;
                            byte_cnt <= '0;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (done) begin
                        state    <= AFTER_DONE;
                        wait_cnt <= '0;
                        gap_cnt  <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout  <= 1'b1;
                        state    <= ST_LOAD;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= ST_READ;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_READ: begin
                    // rd_idx wraps back to zero as the burst ends.
                    res_buf[rd_idx] <= out_data;
                    rd_idx          <= rd_idx + 2'd1;
                    if (rd_idx == RES_LAST) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        send_idx <= send_idx + 2'd1;
                        if (send_idx == RES_LAST) begin
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed self-checking bench for tpu_host_sequencer with a behavioural 2x2 TPU
// that multiplies the loaded matrices and pulses done a few cycles after the last load.
module tb_tpu_host_sequencer;

    localparam logic [63:0] JOB_A  = 64'h0807060504030201;
    localparam logic [31:0] RES_A  = 32'h322B1613;
    localparam logic [63:0] JOB_FF = 64'h02020202FFFFFFFF;
    localparam logic [31:0] RES_FF = 32'hFCFCFCFC;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_last;
    logic       busy;
    logic       timeout;
    logic       load_en;
    logic       load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] in_data;
    logic       output_en;
    logic [1:0] output_sel;
    logic [7:0] out_data;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tpu_host_sequencer #(.DONE_WAIT(2), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_last   (res_last),
        .busy       (busy),
        .timeout    (timeout),
        .load_en    (load_en),
        .load_sel_ab(load_sel_ab),
        .load_index (load_index),
        .in_data    (in_data),
        .output_en  (output_en),
        .output_sel (output_sel),
        .out_data   (out_data),
        .done       (done)
    );

    // Behavioural TPU: row-major A and B storage, combinational product readout.
    logic [7:0]  a_mem [4];
    logic [7:0]  b_mem [4];
    logic [1:0]  done_cnt;
    logic        tpu_done;
    logic        tpu_done_en = 1'b1;
    logic        extra_done  = 1'b0;
    logic [15:0] acc;

    assign done = tpu_done | extra_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= 2'd0;
            tpu_done <= 1'b0;
        end else begin
            tpu_done <= (done_cnt == 2'd1);
            if (done_cnt != 2'd0) done_cnt <= done_cnt - 2'd1;
            if (load_en) begin
                if (load_sel_ab) b_mem[load_index] <= in_data;
                else             a_mem[load_index] <= in_data;
                if (load_sel_ab && load_index == 2'd3 && tpu_done_en) done_cnt <= 2'd3;
            end
        end
    end

    always_comb begin
        acc = 16'(a_mem[{output_sel[1], 1'b0}]) * 16'(b_mem[{1'b0, output_sel[0]}])
            + 16'(a_mem[{output_sel[1], 1'b1}]) * 16'(b_mem[{1'b1, output_sel[0]}]);
        out_data = acc[7:0];
    end

    // Event monitors, sampled on the active edge (pre-update values).
    int          cyc = 0;
    int          to_count = 0;
    int          xfer_cyc [$];
    int          load_cyc [$];
    int          oe_cyc [$];
    int          rv_cyc [$];
    logic [10:0] load_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (timeout) to_count <= to_count + 1;
        if (cmd_valid && cmd_ready) xfer_cyc.push_back(cyc);
        if (load_en) begin
            load_cyc.push_back(cyc);
            load_q.push_back({load_sel_ab, load_index, in_data});
        end
        if (output_en) oe_cyc.push_back(cyc);
        if (res_valid) rv_cyc.push_back(cyc);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required < 100000", $time);
        $fatal(1, "watchdog expired");
    end

    logic [7:0] got [4];
    logic       got_last [4];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input logic [63:0] bytes, input bit toggle);
        int guard;
        for (int k = 0; k < 8; k++) begin
            guard     = 0;
            cmd_valid = 1'b1;
            cmd_data  = bytes[8*k +: 8];
            while (!cmd_ready && guard < 200) begin
                tick();
                guard++;
            end
            if (!cmd_ready) check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
            tick();
            cmd_valid = 1'b0;
            if (toggle) tick();
        end
    endtask

    task automatic recv_results(input int stall);
        int         guard;
        logic [7:0] held_d;
        logic       held_l;
        for (int k = 0; k < 4; k++) begin
            guard     = 0;
            res_ready = 1'b0;
            while (!res_valid && guard < 200) begin
                tick();
                guard++;
            end
            check($sformatf("res_valid_beat%0d", k), {31'd0, res_valid}, 32'd1);
            held_d = res_data;
            held_l = res_last;
            for (int s = 0; s < stall; s++) begin
                tick();
                check("stall_valid", {31'd0, res_valid}, 32'd1);
                check("stall_data", {23'd0, res_last, res_data}, {23'd0, held_l, held_d});
            end
            got[k]      = res_data;
            got_last[k] = res_last;
            res_ready   = 1'b1;
            tick();
            res_ready   = 1'b0;
        end
        check("ready_after_send", {31'd0, cmd_ready}, 32'd1);
        check("valid_after_send", {31'd0, res_valid}, 32'd0);
    endtask

    task automatic check_results(input string tag, input logic [31:0] exp);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_c%0d", tag, k), {24'd0, got[k]}, {24'd0, exp[8*k +: 8]});
            check($sformatf("%s_last%0d", tag, k), {31'd0, got_last[k]}, (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_loads(input string tag, input int base, input logic [63:0] bytes);
        logic [2:0] kk;
        check($sformatf("%s_load_count", tag), load_q.size() - base, 32'd8);
        for (int k = 0; k < 8; k++) begin
            kk = 3'(k);
            check($sformatf("%s_load%0d", tag, k), {21'd0, load_q[base + k]},
                  {21'd0, kk[2], kk[1:0], bytes[8*k +: 8]});
        end
    endtask

    initial begin
        int lb;
        int ob;
        int rb;
        int xb;
        int tb;
        int n;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs",
              {16'd0, load_en, load_sel_ab, load_index, in_data, output_en, output_sel,
               res_valid, res_last, timeout, busy}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // done while idle must not start anything
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        tick();
        check("idle_done_busy", {31'd0, busy}, 32'd0);
        check("idle_done_ready", {31'd0, cmd_ready}, 32'd1);

        // Job 1: reference matrices, contiguous handshakes
        lb = load_q.size();
        ob = oe_cyc.size();
        rb = rv_cyc.size();
        send_job(JOB_A, 1'b0);
        recv_results(0);
        check_loads("job1", lb, JOB_A);
        check_results("job1", RES_A);
        check("job1_oe_pulses", oe_cyc.size() - ob, 32'd4);
        check("job1_latency", oe_cyc[ob] - load_cyc[lb + 7], 32'd7);
        check("job1_read_run", oe_cyc[ob + 3] - oe_cyc[ob], 32'd3);
        check("job1_first_res", rv_cyc[rb] - oe_cyc[ob + 3], 32'd1);

        // Job 2 back-to-back: 0xFF*2 + 0xFF*2 = 1020 -> low byte 0xFC
        lb = load_q.size();
        send_job(JOB_FF, 1'b0);
        recv_results(0);
        check_loads("job2", lb, JOB_FF);
        check_results("job2", RES_FF);

        // Job 3: cmd_valid toggling, host stalls 5 cycles per beat
        lb = load_q.size();
        xb = xfer_cyc.size();
        ob = oe_cyc.size();
        send_job(JOB_A, 1'b1);
        recv_results(5);
        check_loads("job3", lb, JOB_A);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("job3_load_lag%0d", k), load_cyc[lb + k] - xfer_cyc[xb + k], 32'd1);
        end
        check_results("job3", RES_A);
        check("job3_oe_pulses", oe_cyc.size() - ob, 32'd4);

        // Job 4: TPU never raises done
        tpu_done_en = 1'b0;
        ob = oe_cyc.size();
        rb = rv_cyc.size();
        tb = to_count;
        send_job(JOB_A, 1'b0);
        n = 0;
        while (!timeout && n < 50) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 32'd15);
        check("timeout_ready", {31'd0, cmd_ready}, 32'd1);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        tick();
        check("timeout_pulse_width", {31'd0, timeout}, 32'd0);
        check("timeout_count", to_count - tb, 32'd1);
        check("timeout_no_read", oe_cyc.size() - ob, 32'd0);
        check("timeout_no_res", rv_cyc.size() - rb, 32'd0);
        tpu_done_en = 1'b1;

        // Job 5: reset in the middle of the read burst
        send_job(JOB_A, 1'b0);
        n = 0;
        while (!(output_en && output_sel == 2'd2) && n < 100) begin
            tick();
            n++;
        end
        check("reached_read_sel2", {30'd0, output_en, output_sel == 2'd2}, 32'd3);
        rst = 1'b1;
        #1;
        check("midjob_rst_outputs",
              {8'd0, load_en, load_sel_ab, load_index, in_data, output_en, output_sel,
               res_valid, res_last, timeout, busy, res_data}, 32'd0);
        check("midjob_rst_ready", {31'd0, cmd_ready}, 32'd1);
        lb = load_q.size();
        ob = oe_cyc.size();
        rb = rv_cyc.size();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("after_rst_no_pulses",
              {8'd0, 8'(load_q.size() - lb), 8'(oe_cyc.size() - ob), 8'(rv_cyc.size() - rb)}, 32'd0);

        // Job 6: clean job after the abandoned one
        lb = load_q.size();
        send_job(JOB_A, 1'b0);
        recv_results(0);
        check_loads("job6", lb, JOB_A);
        check_results("job6", RES_A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
